// File: rtl/pulse_record_pkg.sv
// rtl/pulse_record_pkg.sv - shared types and constants for the pulse record arbiter
//   arb_state_t : arbiter state encoding (IDLE, WRITE, GAP)
//   clog2       : ceiling log2 for elaboration-time widths
//   DROP_CNT_W  : width of the saturating drop counter
//   GAP_W       : width of the inter-write gap counter
package pulse_record_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } arb_state_t;

  localparam int DROP_CNT_W = 16;
  localparam int GAP_W      = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pulse_record_fifo.sv
// rtl/pulse_record_fifo.sv - per-channel DATA_W x DEPTH record buffer
//   clk, reset_n : clock, asynchronous active-low reset (empties the buffer)
//   push, din    : write request and record; ignored when full
//   pop          : read request; ignored when empty
//   dout         : head-of-buffer record (valid when !empty)
//   empty, full  : occupancy flags, reflect state before the next edge
module pulse_record_fifo
  import pulse_record_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              do_push;
  logic              do_pop;

  // The extra pointer MSB separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pulse_record_arbiter.sv
// rtl/pulse_record_arbiter.sv - round-robin merge of per-channel count records into one FIFO sink
//   clk, reset_n         : clock, asynchronous active-low reset
//   ch_write             : per-channel one-cycle record strobe
//   ch_writedata         : channel i record at [i*DATA_W +: DATA_W]
//   fifo_full            : sink almost-full (at least one slot still free)
//   fifo_write           : one-cycle sink write strobe
//   fifo_writedata       : record presented with fifo_write
//   fifo_channel         : source channel of that record
//   overflow, drop_count : sticky per-channel drop flags, saturating drop total
//   clear_status         : synchronous clear of overflow and drop_count
module pulse_record_arbiter
  import pulse_record_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_W     = 64,
  parameter  int DEPTH      = 4,
  parameter  int GAP_CYCLES = 1,
  localparam int CH_W       = (clog2(NUM_CH) < 1) ? 1 : clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        ch_write,
  input  logic [NUM_CH*DATA_W-1:0] ch_writedata,
  input  logic                     fifo_full,
  output logic                     fifo_write,
  output logic [DATA_W-1:0]        fifo_writedata,
  output logic [CH_W-1:0]          fifo_channel,
  output logic [NUM_CH-1:0]        overflow,
  output logic [DROP_CNT_W-1:0]    drop_count,
  input  logic                     clear_status
);

  logic [NUM_CH-1:0] buf_empty;
  logic [NUM_CH-1:0] buf_full;
  logic [NUM_CH-1:0] pop_vec;
  logic [DATA_W-1:0] buf_dout [NUM_CH];

  arb_state_t        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic              grant_point;
  logic              do_grant;

  logic [NUM_CH-1:0]     drop_vec;
  logic [DROP_CNT_W:0]   drop_sum;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_buf
    pulse_record_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_buf (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (ch_write[g]),
      .pop     (pop_vec[g]),
      .din     (ch_writedata[g*DATA_W +: DATA_W]),
      .dout    (buf_dout[g]),
      .empty   (buf_empty[g]),
      .full    (buf_full[g])
    );
  end

  // First non-empty channel at or after last_grant+1, wrapping.
  always_comb begin
    logic [CH_W-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = CH_W'((int'(last_grant) + 1 + k) % NUM_CH);
      if (!grant_found && !buf_empty[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // A new grant is decided in the last cycle before the arbiter would be
  // idle again: in IDLE, in WRITE when there is no gap, or in the final gap
  // cycle. This keeps writes exactly GAP_CYCLES+1 cycles apart under load.
  always_comb begin
    grant_point = 1'b0;
    case (state)
      IDLE:    grant_point = (gap_cnt == '0);
      WRITE:   grant_point = (GAP_CYCLES == 0);
      GAP:     grant_point = (gap_cnt == GAP_W'(1));
      default: grant_point = 1'b0;
    endcase
    do_grant = grant_point && grant_found && !fifo_full;
    pop_vec  = '0;
    pop_vec[grant_idx] = do_grant;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      gap_cnt        <= '0;
      last_grant     <= CH_W'(NUM_CH - 1);
      fifo_write     <= 1'b0;
      fifo_writedata <= '0;
      fifo_channel   <= '0;
    end else begin
      fifo_write <= do_grant;
      if (do_grant) begin
        fifo_writedata <= buf_dout[grant_idx];
        fifo_channel   <= grant_idx;
        last_grant     <= grant_idx;
      end
      case (state)
        IDLE: begin
          if (do_grant) state <= WRITE;
        end
        WRITE: begin
          gap_cnt <= GAP_W'(GAP_CYCLES);
          if (GAP_CYCLES > 0) state <= GAP;
          else if (do_grant)  state <= WRITE;
          else                state <= IDLE;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt <= GAP_W'(1)) state <= do_grant ? WRITE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Drops are judged against occupancy before the edge; a same-cycle pop
  // never frees room for a push.
  assign drop_vec = ch_write & buf_full;
  assign drop_sum = {1'b0, drop_count} + (DROP_CNT_W + 1)'($countones(drop_vec));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow   <= '0;
      drop_count <= '0;
    end else if (clear_status) begin
      overflow   <= '0;
      drop_count <= '0;
    end else begin
      overflow   <= overflow | drop_vec;
      drop_count <= drop_sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : drop_sum[DROP_CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pulse_record_arbiter.sv
// tb/tb_pulse_record_arbiter.sv - directed scoreboard bench for pulse_record_arbiter
module tb_pulse_record_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [3:0]   ch_write_a, ch_write_b;
  logic [255:0] wdata_a, wdata_b;
  logic         full_a, full_b, clear_a, clear_b;
  logic         fw_a, fw_b;
  logic [63:0]  fd_a, fd_b;
  logic [1:0]   fc_a, fc_b;
  logic [3:0]   ov_a, ov_b;
  logic [15:0]  dc_a, dc_b;

  logic [63:0]  expq_a [4][$];
  logic [63:0]  expq_b [4][$];
  int           chseq_a[$], chseq_b[$];
  int           wcyc_a[$], wcyc_b[$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           cyc = 0;
  int           n_wr_a = 0;
  int           n_wr_b = 0;

  always #10 clk = ~clk;

  pulse_record_arbiter #(.NUM_CH(4), .DATA_W(64), .DEPTH(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .ch_write(ch_write_a), .ch_writedata(wdata_a),
    .fifo_full(full_a), .fifo_write(fw_a), .fifo_writedata(fd_a), .fifo_channel(fc_a),
    .overflow(ov_a), .drop_count(dc_a), .clear_status(clear_a)
  );

  pulse_record_arbiter #(.NUM_CH(4), .DATA_W(64), .DEPTH(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .ch_write(ch_write_b), .ch_writedata(wdata_b),
    .fifo_full(full_b), .fifo_write(fw_b), .fifo_writedata(fd_b), .fifo_channel(fc_b),
    .overflow(ov_b), .drop_count(dc_b), .clear_status(clear_b)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_a();
    if (fw_a === 1'b1) begin
      n_wr_a++;
      if (expq_a[fc_a].size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL a_unexpected_write observed=ch%0d/%0h expected=no write", fc_a, fd_a);
      end else begin
        check("a_record", fd_a, expq_a[fc_a].pop_front());
      end
      chseq_a.push_back(int'(fc_a));
      wcyc_a.push_back(cyc);
    end
  endtask

  task automatic sb_b();
    if (fw_b === 1'b1) begin
      n_wr_b++;
      if (expq_b[fc_b].size() == 0) begin
        n_cmp++;
        n_err++;
        $error("FAIL b_unexpected_write observed=ch%0d/%0h expected=no write", fc_b, fd_b);
      end else begin
        check("b_record", fd_b, expq_b[fc_b].pop_front());
      end
      chseq_b.push_back(int'(fc_b));
      wcyc_b.push_back(cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    sb_a();
    sb_b();
  endtask

  function automatic int pend_a();
    int s = 0;
    for (int c = 0; c < 4; c++) s += expq_a[c].size();
    return s;
  endfunction

  function automatic int pend_b();
    int s = 0;
    for (int c = 0; c < 4; c++) s += expq_b[c].size();
    return s;
  endfunction

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      expq_a[c].delete();
      expq_b[c].delete();
    end
  endtask

  // Strobe the channels in mask for one cycle with record base+ch; channels in
  // keep are expected to be accepted and later written out.
  task automatic push_a(input logic [3:0] mask, input logic [3:0] keep, input logic [63:0] base);
    for (int c = 0; c < 4; c++) begin
      wdata_a[c*64 +: 64] = base + 64'(c);
      if (mask[c] && keep[c]) expq_a[c].push_back(base + 64'(c));
    end
    ch_write_a = mask;
    tick();
    ch_write_a = '0;
  endtask

  task automatic push_b(input logic [3:0] mask, input logic [3:0] keep, input logic [63:0] base);
    for (int c = 0; c < 4; c++) begin
      wdata_b[c*64 +: 64] = base + 64'(c);
      if (mask[c] && keep[c]) expq_b[c].push_back(base + 64'(c));
    end
    ch_write_b = mask;
    tick();
    ch_write_b = '0;
  endtask

  task automatic drain_a(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pend_a() == 0) break;
      tick();
    end
    check(tag, 64'(pend_a()), 64'd0);
  endtask

  task automatic drain_b(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (pend_b() == 0) break;
      tick();
    end
    check(tag, 64'(pend_b()), 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    int s0;
    int w0;
    reset_n    = 1'b0;
    ch_write_a = '0; ch_write_b = '0;
    wdata_a    = '0; wdata_b    = '0;
    full_a     = 1'b0; full_b   = 1'b0;
    clear_a    = 1'b0; clear_b  = 1'b0;
    tick();
    tick();
    check("rst_fifo_write", 64'(fw_a), 64'd0);
    check("rst_writedata", fd_a, 64'd0);
    check("rst_channel", 64'(fc_a), 64'd0);
    check("rst_overflow", 64'(ov_a), 64'd0);
    check("rst_drop_count", 64'(dc_a), 64'd0);
    reset_n = 1'b1;
    tick();

    // Single record on channel 2: strobe in cycle 0, write in cycle 2 only.
    push_a(4'b0100, 4'b0100, 64'h0123_4567_89AB_CDED);
    check("t1_cycle1_idle", 64'(fw_a), 64'd0);
    tick();
    check("t1_cycle2_write", 64'(fw_a), 64'd1);
    check("t1_channel", 64'(fc_a), 64'd2);
    check("t1_data", fd_a, 64'h0123_4567_89AB_CDEF);
    tick();
    check("t1_cycle3_idle", 64'(fw_a), 64'd0);
    check("t1_channel_hold", 64'(fc_a), 64'd2);
    check("t1_data_hold", fd_a, 64'h0123_4567_89AB_CDEF);

    // All channels at once, gap 1: round-robin from ch0, writes two cycles apart.
    do_reset();
    s0 = chseq_a.size();
    push_a(4'hF, 4'hF, 64'hA000);
    drain_a("t2_drain", 40);
    check("t2_write_count", 64'(chseq_a.size() - s0), 64'd4);
    if (chseq_a.size() - s0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t2_order", 64'(chseq_a[s0+k]), 64'(k));
        if (k > 0) check("t2_spacing", 64'(wcyc_a[s0+k] - wcyc_a[s0+k-1]), 64'd2);
      end
    end
    check("t2_no_drop", 64'(dc_a), 64'd0);
    check("t2_no_overflow", 64'(ov_a), 64'd0);

    // Six back-to-back strobes on ch0 while the sink is full: four kept, two dropped.
    full_a = 1'b1;
    w0 = n_wr_a;
    for (int i = 0; i < 6; i++) push_a(4'b0001, (i < 4) ? 4'b0001 : 4'b0000, 64'hB000 + 64'(i * 16));
    tick();
    tick();
    check("t3_held_by_full", 64'(n_wr_a - w0), 64'd0);
    check("t3_overflow", 64'(ov_a), 64'h1);
    check("t3_drop_count", 64'(dc_a), 64'd2);
    full_a = 1'b0;
    drain_a("t3_drain", 40);
    for (int i = 0; i < 6; i++) tick();
    check("t3_drained_four", 64'(n_wr_a - w0), 64'd4);

    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clr_overflow", 64'(ov_a), 64'd0);
    check("clr_drop_count", 64'(dc_a), 64'd0);

    // A drop coinciding with clear_status is not counted.
    full_a = 1'b1;
    for (int i = 0; i < 4; i++) push_a(4'b0001, 4'b0001, 64'hC000 + 64'(i * 16));
    clear_a = 1'b1;
    push_a(4'b0001, 4'b0000, 64'hC0F0);
    clear_a = 1'b0;
    check("clrwin_drop_count", 64'(dc_a), 64'd0);
    check("clrwin_overflow", 64'(ov_a), 64'd0);

    // Fill the other channels, then a four-way simultaneous drop.
    for (int i = 0; i < 4; i++) push_a(4'b1110, 4'b1110, 64'hD000 + 64'(i * 16));
    push_a(4'hF, 4'h0, 64'hE000);
    check("multi_drop_count", 64'(dc_a), 64'd4);
    check("multi_overflow", 64'(ov_a), 64'hF);
    s0 = chseq_a.size();
    full_a = 1'b0;
    drain_a("multi_drain", 80);
    check("multi_write_count", 64'(chseq_a.size() - s0), 64'd16);
    if (chseq_a.size() - s0 == 16) begin
      // last grant before this drain was ch0, so rotation starts at ch1
      for (int k = 0; k < 16; k++) check("multi_rr_order", 64'(chseq_a[s0+k]), 64'((k + 1) % 4));
    end

    // fifo_full raised during the write cycle: that write completes, next waits.
    do_reset();
    w0 = n_wr_a;
    push_a(4'b0110, 4'b0110, 64'hF000);
    tick();
    check("t4_write_in_flight", 64'(fw_a), 64'd1);
    check("t4_first_channel", 64'(fc_a), 64'd1);
    full_a = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("t4_held", 64'(n_wr_a - w0), 64'd1);
    full_a = 1'b0;
    drain_a("t4_drain", 20);
    check("t4_total", 64'(n_wr_a - w0), 64'd2);

    // Reset while a write is in flight and three records remain buffered.
    do_reset();
    push_a(4'hF, 4'hF, 64'h5000);
    tick();
    check("t5_write_before_reset", 64'(fw_a), 64'd1);
    reset_n = 1'b0;
    #1;
    check("t5_async_drop", 64'(fw_a), 64'd0);
    clear_model();
    w0 = n_wr_a;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("t5_no_writes", 64'(n_wr_a - w0), 64'd0);
    check("t5_overflow", 64'(ov_a), 64'd0);
    check("t5_drop_count", 64'(dc_a), 64'd0);
    check("t5_writedata", fd_a, 64'd0);

    // Gap 0: channels 1 and 3 hold two records each -> 1,3,1,3 on consecutive cycles.
    full_b = 1'b1;
    push_b(4'b1010, 4'b1010, 64'h6000);
    push_b(4'b1010, 4'b1010, 64'h6100);
    s0 = chseq_b.size();
    full_b = 1'b0;
    drain_b("t6_drain", 20);
    check("t6_write_count", 64'(chseq_b.size() - s0), 64'd4);
    if (chseq_b.size() - s0 == 4) begin
      for (int k = 0; k < 4; k++) begin
        check("t6_order", 64'(chseq_b[s0+k]), (k % 2 == 0) ? 64'd1 : 64'd3);
        if (k > 0) check("t6_back_to_back", 64'(wcyc_b[s0+k] - wcyc_b[s0+k-1]), 64'd1);
      end
    end

    // Drops on gap-0 instance, then clear; buffered records survive the clear.
    full_b = 1'b1;
    for (int i = 0; i < 5; i++) push_b(4'b0001, (i < 4) ? 4'b0001 : 4'b0000, 64'h7000 + 64'(i * 16));
    check("t6_pre_clear_overflow", 64'(ov_b), 64'h1);
    check("t6_pre_clear_drops", 64'(dc_b), 64'd1);
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    check("t6_clear_overflow", 64'(ov_b), 64'd0);
    check("t6_clear_drops", 64'(dc_b), 64'd0);
    w0 = n_wr_b;
    full_b = 1'b0;
    drain_b("t6_post_clear_drain", 20);
    check("t6_buffers_kept", 64'(n_wr_b - w0), 64'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
